// File: rtl/token_ring_ctrl.sv
// Token-ring pointer controller: one token in a DEPTH-cell ring,
// multi-cell advance with lap parity, stall and illegal-step flags.
module token_ring_ctrl #(
  parameter int DEPTH = 8,
  parameter int INIT_POS = 0,
  parameter int STEP_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              init,
  input  logic              hold,
  input  logic              adv,
  input  logic [STEP_W-1:0] step,
  output logic [DEPTH-1:0]  tok,
  output logic [DEPTH-1:0]  tok_gated,
  output logic [PTR_W-1:0]  ptr,
  output logic              lap,
  output logic              active,
  output logic              wrap,
  output logic              stall,
  output logic              step_err
);

  localparam int SUM_W = PTR_W + 1;

  typedef enum logic {
    EMPTY = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [DEPTH-1:0]  tok_q, tok_d;
  logic              lap_q, lap_d;
  logic              wrap_q, wrap_d;
  logic              step_err_q, step_err_d;
  logic [SUM_W-1:0]  sum;
  logic              step_bad;

  // Max sum is 2*DEPTH-1, which always fits in PTR_W+1 bits.
  assign sum = {1'b0, ptr_q} + SUM_W'(step);
  assign step_bad = 32'(step) > DEPTH;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    tok_d      = tok_q;
    lap_d      = lap_q;
    wrap_d     = 1'b0;
    step_err_d = 1'b0;
    if (!enable) begin
      state_d = state_q;
    end else if (init) begin
      state_d = RUN;
      ptr_d   = PTR_W'(INIT_POS);
      lap_d   = 1'b0;
      tok_d   = '0;
      tok_d[ptr_d] = 1'b1;
    end else if (state_q == RUN && !hold && adv) begin
      if (step_bad) begin
        step_err_d = 1'b1;
      end else begin
        if (sum >= SUM_W'(DEPTH)) begin
          ptr_d  = PTR_W'(sum - SUM_W'(DEPTH));
          lap_d  = ~lap_q;
          wrap_d = 1'b1;
        end else begin
          ptr_d  = PTR_W'(sum);
        end
        tok_d = '0;
        tok_d[ptr_d] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      ptr_q      <= '0;
      tok_q      <= '0;
      lap_q      <= 1'b0;
      wrap_q     <= 1'b0;
      step_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      tok_q      <= tok_d;
      lap_q      <= lap_d;
      wrap_q     <= wrap_d;
      step_err_q <= step_err_d;
    end
  end

  assign tok      = tok_q;
  assign ptr      = ptr_q;
  assign lap      = lap_q;
  assign active   = (state_q == RUN);
  assign wrap     = wrap_q;
  assign step_err = step_err_q;

  assign tok_gated = (enable && !hold && active) ? tok_q : '0;
  assign stall = adv & enable & ~init & (hold | ~active);

endmodule

// File: tb/tb_token_ring_ctrl.sv
// Directed self-checking bench for token_ring_ctrl
// with DEPTH=8, INIT_POS=3.
module tb_token_ring_ctrl;

  localparam int DEPTH = 8;
  localparam int STEP_W = 4;

  logic              clk = 1'b0;
  logic              reset, enable, init, hold, adv;
  logic [STEP_W-1:0] step;
  logic [DEPTH-1:0]  tok, tok_gated;
  logic [2:0]        ptr;
  logic              lap, active, wrap, stall, step_err;

  int n_checks = 0;
  int n_fail = 0;

  token_ring_ctrl #(.DEPTH(DEPTH), .INIT_POS(3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .init(init),
    .hold(hold), .adv(adv), .step(step), .tok(tok),
    .tok_gated(tok_gated), .ptr(ptr), .lap(lap),
    .active(active), .wrap(wrap), .stall(stall),
    .step_err(step_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; enable = 1; init = 0; hold = 0; adv = 0; step = 0;
    tick();
    n_checks++; if (tok !== 8'h00) begin n_fail++; $display("FAIL reset_tok: got %h want 00", tok); end
    n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", active); end
    n_checks++; if (ptr !== 3'd0 || lap !== 1'b0) begin n_fail++; $display("FAIL reset_ptr_lap: got %0d/%b want 0/0", ptr, lap); end
    n_checks++; if (wrap !== 1'b0 || step_err !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got %b%b want 00", wrap, step_err); end
    n_checks++; if (tok_gated !== 8'h00 || stall !== 1'b0) begin n_fail++; $display("FAIL reset_comb: got %h/%b want 00/0", tok_gated, stall); end
    reset = 0;
  endtask

  task automatic test_empty_stall();
    adv = 1; step = 1;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL empty_stall: got %b want 1", stall); end
    tick();
    n_checks++; if (active !== 1'b0 || tok !== 8'h00) begin n_fail++; $display("FAIL empty_hold: got %b/%h want 0/00", active, tok); end
    adv = 0;
  endtask

  task automatic test_init();
    init = 1;
    tick();
    init = 0;
    n_checks++; if (tok !== 8'h08) begin n_fail++; $display("FAIL init_tok: got %h want 08", tok); end
    n_checks++; if (ptr !== 3'd3 || lap !== 1'b0 || active !== 1'b1) begin n_fail++; $display("FAIL init_state: got %0d/%b/%b want 3/0/1", ptr, lap, active); end
  endtask

  task automatic test_step1();
    logic [2:0] exp_ptr [5];
    exp_ptr = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    adv = 1; step = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (ptr !== exp_ptr[i]) begin n_fail++; $display("FAIL step1_ptr[%0d]: got %0d want %0d", i, ptr, exp_ptr[i]); end
      n_checks++; if (wrap !== (i == 4)) begin n_fail++; $display("FAIL step1_wrap[%0d]: got %b want %b", i, wrap, i == 4); end
      n_checks++; if (lap !== (i == 4)) begin n_fail++; $display("FAIL step1_lap[%0d]: got %b want %b", i, lap, i == 4); end
    end
    n_checks++; if (tok !== 8'h01) begin n_fail++; $display("FAIL step1_tok: got %h want 01", tok); end
    adv = 0;
  endtask

  task automatic test_big_steps();
    init = 1;
    tick();
    init = 0; adv = 1; step = 3;
    tick();
    n_checks++; if (ptr !== 3'd6 || lap !== 1'b0 || wrap !== 1'b0) begin n_fail++; $display("FAIL big_pre: got %0d/%b/%b want 6/0/0", ptr, lap, wrap); end
    step = 5;
    tick();
    n_checks++; if (ptr !== 3'd3 || lap !== 1'b1 || wrap !== 1'b1) begin n_fail++; $display("FAIL big_step5: got %0d/%b/%b want 3/1/1", ptr, lap, wrap); end
    step = 8;
    tick();
    n_checks++; if (ptr !== 3'd3 || lap !== 1'b0 || wrap !== 1'b1) begin n_fail++; $display("FAIL big_step8: got %0d/%b/%b want 3/0/1", ptr, lap, wrap); end
    n_checks++; if (tok !== 8'h08) begin n_fail++; $display("FAIL big_step8_tok: got %h want 08", tok); end
    step = 0;
    tick();
    n_checks++; if (ptr !== 3'd3 || lap !== 1'b0 || wrap !== 1'b0) begin n_fail++; $display("FAIL big_step0: got %0d/%b/%b want 3/0/0", ptr, lap, wrap); end
    adv = 0;
  endtask

  task automatic test_hold();
    hold = 1; adv = 1; step = 2;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (stall !== 1'b1 || tok_gated !== 8'h00) begin n_fail++; $display("FAIL hold_comb[%0d]: got %b/%h want 1/00", i, stall, tok_gated); end
      tick();
      n_checks++; if (ptr !== 3'd3 || tok !== 8'h08) begin n_fail++; $display("FAIL hold_ptr[%0d]: got %0d/%h want 3/08", i, ptr, tok); end
    end
    hold = 0;
    #1;
    n_checks++; if (stall !== 1'b0 || tok_gated !== 8'h08) begin n_fail++; $display("FAIL release_comb: got %b/%h want 0/08", stall, tok_gated); end
    tick();
    n_checks++; if (ptr !== 3'd5 || tok !== 8'h20) begin n_fail++; $display("FAIL release_adv: got %0d/%h want 5/20", ptr, tok); end
    adv = 0;
  endtask

  task automatic test_step_err();
    adv = 1; step = 9;
    tick();
    n_checks++; if (step_err !== 1'b1 || ptr !== 3'd5 || wrap !== 1'b0) begin n_fail++; $display("FAIL step_err_set: got %b/%0d/%b want 1/5/0", step_err, ptr, wrap); end
    adv = 0;
    tick();
    n_checks++; if (step_err !== 1'b0 || ptr !== 3'd5) begin n_fail++; $display("FAIL step_err_clr: got %b/%0d want 0/5", step_err, ptr); end
  endtask

  task automatic test_init_adv();
    init = 1; adv = 1; step = 2;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL init_adv_stall: got %b want 0", stall); end
    tick();
    n_checks++; if (ptr !== 3'd3 || lap !== 1'b0 || tok !== 8'h08) begin n_fail++; $display("FAIL init_adv: got %0d/%b/%h want 3/0/08", ptr, lap, tok); end
    init = 0; adv = 0;
  endtask

  task automatic test_enable();
    adv = 1; step = 2;
    tick();
    step = 6;
    tick();
    n_checks++; if (ptr !== 3'd3 || lap !== 1'b1 || wrap !== 1'b1) begin n_fail++; $display("FAIL en_pre: got %0d/%b/%b want 3/1/1", ptr, lap, wrap); end
    enable = 0; init = 1; adv = 1; step = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (ptr !== 3'd3 || lap !== 1'b1 || tok !== 8'h08 || active !== 1'b1) begin n_fail++; $display("FAIL en_freeze[%0d]: got %0d/%b/%h/%b want 3/1/08/1", i, ptr, lap, tok, active); end
      n_checks++; if (wrap !== 1'b0 || tok_gated !== 8'h00 || stall !== 1'b0) begin n_fail++; $display("FAIL en_freeze_out[%0d]: got %b/%h/%b want 0/00/0", i, wrap, tok_gated, stall); end
    end
    enable = 1; init = 0;
    tick();
    n_checks++; if (ptr !== 3'd4 || lap !== 1'b1) begin n_fail++; $display("FAIL en_resume: got %0d/%b want 4/1", ptr, lap); end
  endtask

  task automatic test_reset_midrun();
    reset = 1;
    tick();
    reset = 0;
    n_checks++; if (tok !== 8'h00 || active !== 1'b0 || lap !== 1'b0) begin n_fail++; $display("FAIL midrun_reset: got %h/%b/%b want 00/0/0", tok, active, lap); end
    tick();
    n_checks++; if (active !== 1'b0 || ptr !== 3'd0) begin n_fail++; $display("FAIL midrun_stay_empty: got %b/%0d want 0/0", active, ptr); end
    adv = 0;
  endtask

  initial begin
    test_reset();
    test_empty_stall();
    test_init();
    test_step1();
    test_big_steps();
    test_hold();
    test_step_err();
    test_init_adv();
    test_enable();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
